// File: rtl/or_split_pkg.sv
// Shared types and constants for the or_split16 mask decomposer.
// Optional build macro: OR_SPLIT_MSB_FIRST_EN (highest-set-bit-first scan order).
package or_split_pkg;

    // Datapath word width and the matching bit-index width.
    localparam int WIDTH = 16;
    localparam int IDX_W = 4;

    // Two-state control: waiting for a word, or streaming its beats.
    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    // One 16-bit beat or word.
    typedef logic [WIDTH-1:0] onehot_t;

    // Bit position within a word.
    typedef logic [IDX_W-1:0] index_t;

    // Removes the bits of a one-hot beat from a word.
    function automatic onehot_t clear_bits(input onehot_t word, input onehot_t beat);
        return word & ~beat;
    endfunction

endpackage

// File: rtl/bit_find16.sv
// Combinational priority finder: locates one set bit of a 16-bit word and
// returns its position and one-hot mask. Default order picks the lowest set
// bit; defining OR_SPLIT_MSB_FIRST_EN picks the highest set bit instead.
module bit_find16
    import or_split_pkg::*;
(
    input  onehot_t word_i,
    output logic    found_o,
    output index_t  index_o,
    output onehot_t onehot_o
);

    // Scan so the winning bit is written last; an all-zero word yields found=0, index 0, mask 0.
    always_comb begin
        found_o  = 1'b0;
        index_o  = '0;
        onehot_o = '0;
`ifdef OR_SPLIT_MSB_FIRST_EN
        for (int i = 0; i < WIDTH; i++) begin
            if (word_i[i]) begin
                found_o = 1'b1;
                index_o = IDX_W'(i);
            end
        end
`else
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (word_i[i]) begin
                found_o = 1'b1;
                index_o = IDX_W'(i);
            end
        end
`endif
        if (found_o) begin
            onehot_o = onehot_t'(1) << index_o;
        end
    end

endmodule

// File: rtl/or_split16.sv
// or_split16: splits an accepted 16-bit word into a stream of one-hot beats,
// one per set bit (a zero word gives a single all-zero beat). OR of the beats
// rebuilds the word. Scan order is set inside bit_find16 by the optional
// macro OR_SPLIT_MSB_FIRST_EN; the handshake is identical in both builds.
module or_split16 #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_onehot,
    output logic [IDX_W-1:0] out_index,
    output logic             out_last
);

    import or_split_pkg::*;

    state_e  state_q,   state_d;
    onehot_t residue_q, residue_d;
    onehot_t onehot_q,  onehot_d;
    index_t  index_q,   index_d;
    logic    last_q,    last_d;
    logic    valid_q,   valid_d;

    logic    accept;
    logic    loadBeat;
    onehot_t srcWord;
    logic    findFound;
    index_t  findIndex;
    onehot_t findOnehot;
    onehot_t nextResidue;

    // A new word may enter when idle, or in the same cycle the final beat of the current word leaves.
    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            in_ready = (state_q == IDLE) || (valid_q && out_ready && last_q);
        end
        accept = in_valid && in_ready;
    end

    // The single finder looks at the incoming word whenever one is accepted, otherwise at the residue.
    always_comb begin
        srcWord = residue_q;
        if (accept) begin
            srcWord = in_word;
        end
    end

    bit_find16 u_find (
        .word_i   (srcWord),
        .found_o  (findFound),
        .index_o  (findIndex),
        .onehot_o (findOnehot)
    );

    // Whatever is left after the beat being loaded decides whether that beat is the last one.
    always_comb begin
        nextResidue = '0;
        if (findFound) begin
            nextResidue = clear_bits(srcWord, findOnehot);
        end
    end

    // Next-state logic: load a beat on accept or on an advancing handshake, drop to idle after the last beat.
    always_comb begin
        state_d   = state_q;
        residue_d = residue_q;
        onehot_d  = onehot_q;
        index_d   = index_q;
        last_d    = last_q;
        valid_d   = valid_q;
        loadBeat  = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    loadBeat = 1'b1;
                    state_d  = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (!last_q || accept) begin
                        loadBeat = 1'b1;
                    end else begin
                        state_d   = IDLE;
                        valid_d   = 1'b0;
                        onehot_d  = '0;
                        index_d   = '0;
                        last_d    = 1'b0;
                        residue_d = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase

        if (loadBeat) begin
            onehot_d  = findOnehot;
            index_d   = findIndex;
            residue_d = nextResidue;
            last_d    = (nextResidue == '0);
            valid_d   = 1'b1;
        end
    end

    // State and output registers; a synchronous reset clears everything and discards any word in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            residue_q <= '0;
            onehot_q  <= '0;
            index_q   <= '0;
            last_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            residue_q <= residue_d;
            onehot_q  <= onehot_d;
            index_q   <= index_d;
            last_q    <= last_d;
            valid_q   <= valid_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_onehot = onehot_q;
    assign out_index  = index_q;
    assign out_last   = last_q;

endmodule

// File: tb/tb_or_split16.sv
// Scoreboard bench for or_split16. The driver predicts the beat list of each
// accepted word from its set bits and queues it; a separate monitor pops and
// compares on every output handshake. Honours OR_SPLIT_MSB_FIRST_EN.
module tb_or_split16;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_word;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_onehot;
    logic [3:0]  out_index;
    logic        out_last;

    typedef struct {
        logic [15:0] oh;
        logic [3:0]  idx;
        logic        last;
        logic [15:0] word;
    } beat_t;

    beat_t expQ[$];
    int    hsCycles[$];
    bit    readyPattern[$];
    int    readyPct    = 100;
    int    cycleCnt    = 0;
    int    acceptCycle = 0;
    int    numChecks   = 0;
    int    numFails    = 0;

    or_split16 #(.WIDTH(16), .IDX_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_word    (in_word),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_onehot (out_onehot),
        .out_index  (out_index),
        .out_last   (out_last)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle counter used to measure latency and bubbles between handshakes.
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Safety net so the run can never hang.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required finish before it");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference model: one beat per set bit in scan order, or one zero beat for a zero word.
    function automatic void pushExpected(input logic [15:0] w);
        int    pos[$];
        beat_t b;
        for (int k = 0; k < 16; k++) begin
            if (w[k]) pos.push_back(k);
        end
`ifdef OR_SPLIT_MSB_FIRST_EN
        pos.reverse();
`endif
        if (pos.size() == 0) begin
            b.oh = 16'h0000; b.idx = 4'd0; b.last = 1'b1; b.word = w;
            expQ.push_back(b);
        end else begin
            for (int k = 0; k < pos.size(); k++) begin
                b.oh   = 16'h0001 << pos[k];
                b.idx  = 4'(pos[k]);
                b.last = (k == pos.size() - 1);
                b.word = w;
                expQ.push_back(b);
            end
        end
    endfunction

    // One clock cycle: drive out_ready, spot an accept before the edge, then move past the edge.
    task automatic stepCycle(output bit accepted);
        @(negedge clk);
        if (readyPattern.size() > 0) out_ready = readyPattern.pop_front();
        else                         out_ready = ($urandom_range(99) < readyPct);
        #1;
        accepted = 1'b0;
        if (in_valid && in_ready && !rst) begin
            pushExpected(in_word);
            acceptCycle = cycleCnt;
            accepted    = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [15:0] w);
        bit acc = 1'b0;
        in_valid = 1'b1;
        in_word  = w;
        for (int i = 0; i < 200 && !acc; i++) stepCycle(acc);
        checkOutput("accept_timeout", 32'(acc), 32'd1);
        in_valid = 1'b0;
        in_word  = 16'($urandom);
    endtask

    task automatic idleCycles(input int n);
        bit acc;
        for (int i = 0; i < n; i++) stepCycle(acc);
    endtask

    task automatic drain(input int budget);
        bit acc;
        for (int i = 0; i < budget && (expQ.size() > 0 || out_valid); i++) stepCycle(acc);
        checkOutput("drain_queue_empty", 32'(expQ.size()), 32'd0);
        checkOutput("drain_out_valid", 32'(out_valid), 32'd0);
    endtask

    // Monitor: compares each delivered beat with the queue, checks hold-under-stall and in_ready.
    logic [15:0] orAcc = 16'h0;
    bit          holdPending = 1'b0;
    logic [15:0] holdOh;
    logic [3:0]  holdIdx;
    logic        holdLast;
    always @(negedge clk) begin
        beat_t b;
        logic  expLast;
        #2;
        if (rst) begin
            holdPending = 1'b0;
            orAcc       = 16'h0;
        end else begin
            if (holdPending) begin
                checkOutput("hold_valid", 32'(out_valid), 32'd1);
                checkOutput("hold_onehot", 32'(out_onehot), 32'(holdOh));
                checkOutput("hold_index", 32'(out_index), 32'(holdIdx));
                checkOutput("hold_last", 32'(out_last), 32'(holdLast));
                holdPending = 1'b0;
            end
            expLast = (expQ.size() > 0) ? expQ[0].last : 1'b0;
            if (out_valid) checkOutput("in_ready_busy", 32'(in_ready), 32'(out_ready && expLast));
            else           checkOutput("in_ready_idle", 32'(in_ready), 32'd1);
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_beat", 32'(out_valid), 32'd0);
                end else begin
                    b = expQ.pop_front();
                    checkOutput("beat_onehot", 32'(out_onehot), 32'(b.oh));
                    checkOutput("beat_index", 32'(out_index), 32'(b.idx));
                    checkOutput("beat_last", 32'(out_last), 32'(b.last));
                    orAcc = orAcc | out_onehot;
                    if (b.last) begin
                        checkOutput("or_rebuild", 32'(orAcc), 32'(b.word));
                        orAcc = 16'h0;
                    end
                    hsCycles.push_back(cycleCnt);
                end
            end else if (out_valid) begin
                holdPending = 1'b1;
                holdOh      = out_onehot;
                holdIdx     = out_index;
                holdLast    = out_last;
            end
        end
    end

    // Directed scenarios first, then a randomized stream with random backpressure.
    initial begin
        int          base;
        int          accC;
        int          sel;
        logic [15:0] w;

        rst       = 1'b1;
        in_valid  = 1'b1;
        in_word   = 16'h1234;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_onehot", 32'(out_onehot), 32'd0);
        checkOutput("reset_index", 32'(out_index), 32'd0);
        checkOutput("reset_last", 32'(out_last), 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        rst      = 1'b0;
        #1;
        checkOutput("post_reset_in_ready", 32'(in_ready), 32'd1);
        idleCycles(1);
        checkOutput("reset_dropped_word", 32'(out_valid), 32'd0);

        readyPct = 100;
        base = hsCycles.size();
        applyStimulus(16'hA005);
        accC = acceptCycle;
        drain(50);
        checkOutput("a005_beats", 32'(hsCycles.size() - base), 32'd4);
        if (hsCycles.size() - base == 4) begin
            checkOutput("a005_latency", 32'(hsCycles[base]), 32'(accC + 1));
            checkOutput("a005_span", 32'(hsCycles[base+3] - hsCycles[base]), 32'd3);
        end

        base = hsCycles.size();
        applyStimulus(16'h0000);
        accC = acceptCycle;
        drain(50);
        checkOutput("zero_beats", 32'(hsCycles.size() - base), 32'd1);
        if (hsCycles.size() - base == 1) checkOutput("zero_latency", 32'(hsCycles[base]), 32'(accC + 1));

        base = hsCycles.size();
        applyStimulus(16'hFFFF);
        drain(50);
        checkOutput("ffff_beats", 32'(hsCycles.size() - base), 32'd16);
        if (hsCycles.size() - base == 16) checkOutput("ffff_span", 32'(hsCycles[base+15] - hsCycles[base]), 32'd15);

        base = hsCycles.size();
        readyPattern = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        applyStimulus(16'h0110);
        drain(50);
        checkOutput("bp_beats", 32'(hsCycles.size() - base), 32'd2);
        if (hsCycles.size() - base == 2) checkOutput("bp_stall_gap", 32'(hsCycles[base+1] - hsCycles[base]), 32'd3);

        base = hsCycles.size();
        applyStimulus(16'h0003);
        applyStimulus(16'h8000);
        drain(50);
        checkOutput("b2b_beats", 32'(hsCycles.size() - base), 32'd3);
        if (hsCycles.size() - base == 3) checkOutput("b2b_no_bubble", 32'(hsCycles[base+2] - hsCycles[base]), 32'd2);

        applyStimulus(16'h00F0);
        idleCycles(2);
        rst = 1'b1;
        expQ.delete();
        idleCycles(1);
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_onehot", 32'(out_onehot), 32'd0);
        checkOutput("midrst_index", 32'(out_index), 32'd0);
        checkOutput("midrst_last", 32'(out_last), 32'd0);
        rst = 1'b0;
        base = hsCycles.size();
        applyStimulus(16'h0001);
        drain(50);
        checkOutput("midrst_next_beats", 32'(hsCycles.size() - base), 32'd1);

        readyPct = 70;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(3) == 0) idleCycles(1);
            sel = int'($urandom_range(7));
            case (sel)
                0:       w = 16'h0000;
                1:       w = 16'hFFFF;
                2:       w = 16'h0001 << $urandom_range(15);
                default: w = 16'($urandom);
            endcase
            applyStimulus(w);
        end
        drain(2000);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
